// File: rtl/mem_arbiter.sv
// Shares one single-port, 1-cycle-latency RAM between instruction-fetch and data ports.
// MEM has priority; a starvation counter bounds how long a waiting IF request can be held off.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rstn_i,

    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,

    input  logic                    mem_req_i,
    input  logic [DATA_WIDTH/8-1:0] mem_we_i,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    output logic                    mem_gnt_o,
    output logic                    mem_rvalid_o,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,

    output logic                    ram_en_o,
    output logic [DATA_WIDTH/8-1:0] ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    typedef enum logic {OwnIf, OwnMem} owner_e;

    logic [3:0] starve_cnt_q, starve_cnt_d;
    owner_e     resp_owner_q, resp_owner_d;
    logic       resp_pend_q, resp_pend_d;
    logic       starved;

    assign starved = (starve_cnt_q >= 4'(STARVE_LIMIT));

    // Grants are gated by reset so they drop immediately on asynchronous assertion.
    always_comb begin
        if_gnt_o  = 1'b0;
        mem_gnt_o = 1'b0;
        if (rstn_i) begin
            if (mem_req_i && (!if_req_i || !starved)) begin
                mem_gnt_o = 1'b1;
            end else if (if_req_i) begin
                if_gnt_o = 1'b1;
            end
        end
    end

    always_comb begin
        ram_we_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (mem_gnt_o) begin
            ram_we_o    = mem_we_i;
            ram_addr_o  = mem_addr_i;
            ram_wdata_o = mem_wdata_i;
        end else if (if_gnt_o) begin
            ram_addr_o  = if_addr_i;
        end
    end

    assign ram_en_o = if_gnt_o | mem_gnt_o;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_gnt_o || !if_req_i) begin
            starve_cnt_d = 4'd0;
        end else if (mem_gnt_o) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_comb begin
        resp_pend_d  = ram_en_o;
        resp_owner_d = resp_owner_q;
        if (mem_gnt_o) begin
            resp_owner_d = OwnMem;
        end else if (if_gnt_o) begin
            resp_owner_d = OwnIf;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            starve_cnt_q <= 4'd0;
            resp_owner_q <= OwnIf;
            resp_pend_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            resp_owner_q <= resp_owner_d;
            resp_pend_q  <= resp_pend_d;
        end
    end

    always_comb begin
        if_rvalid_o  = resp_pend_q && (resp_owner_q == OwnIf);
        mem_rvalid_o = resp_pend_q && (resp_owner_q == OwnMem);
        if_rdata_o   = if_rvalid_o  ? ram_rdata_i : '0;
        mem_rdata_o  = mem_rvalid_o ? ram_rdata_i : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter with a write-first RAM model,
// a transaction-level reference memory and response scoreboards per port.
module tb_mem_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned LIMIT = 4;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          wr;
    } resp_t;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o, if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          mem_req_i;
    logic [BW-1:0] mem_we_i;
    logic [AW-1:0] mem_addr_i;
    logic [DW-1:0] mem_wdata_i;
    logic          mem_gnt_o, mem_rvalid_o;
    logic [DW-1:0] mem_rdata_o;
    logic          ram_en_o;
    logic [BW-1:0] ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i;

    mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_gnt_o   (mem_gnt_o),
        .mem_rvalid_o(mem_rvalid_o),
        .mem_rdata_o (mem_rdata_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++) if (we[b]) v[b*8 +: 8] = wd[b*8 +: 8];
        return v;
    endfunction

    // Write-first single-port RAM, 64 words.
    logic [31:0] tb_ram [64];
    always @(posedge clk) begin
        if (ram_en_o) begin
            tb_ram[ram_addr_o[7:2]] <= merge(tb_ram[ram_addr_o[7:2]], ram_wdata_o, ram_we_o);
            ram_rdata_i             <= merge(tb_ram[ram_addr_o[7:2]], ram_wdata_o, ram_we_o);
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] ref_mem [64];
    resp_t       if_q[$];
    resp_t       mem_q[$];

    bit          if_p = 1'b0, mem_p = 1'b0;
    logic [31:0] if_a, mem_a, mem_wd;
    logic [3:0]  mem_we;
    int          if_wait = 0;
    bit          got_if, got_mem;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented response against the scoreboard queues.
    always @(posedge clk) begin
        resp_t e;
        cyc++;
        #1;
        if (rstn_i) begin
            if (if_rvalid_o) begin
                if (if_q.size() == 0) begin
                    chk("if_rvalid unexpected", 32'(if_rvalid_o), 32'd0);
                end else begin
                    e = if_q.pop_front();
                    chk("if_resp cycle", cyc, e.cyc);
                    chk("if_rdata", if_rdata_o, e.data);
                end
            end else begin
                chk("if_rdata idle zero", if_rdata_o, 32'd0);
                if (if_q.size() != 0 && if_q[0].cyc <= cyc) begin
                    e = if_q.pop_front();
                    chk("if_rvalid missing", 32'(if_rvalid_o), 32'd1);
                end
            end
            if (mem_rvalid_o) begin
                if (mem_q.size() == 0) begin
                    chk("mem_rvalid unexpected", 32'(mem_rvalid_o), 32'd0);
                end else begin
                    e = mem_q.pop_front();
                    chk("mem_resp cycle", cyc, e.cyc);
                    if (!e.wr) chk("mem_rdata", mem_rdata_o, e.data);
                end
            end else begin
                chk("mem_rdata idle zero", mem_rdata_o, 32'd0);
                if (mem_q.size() != 0 && mem_q[0].cyc <= cyc) begin
                    e = mem_q.pop_front();
                    chk("mem_rvalid missing", 32'(mem_rvalid_o), 32'd1);
                end
            end
        end
    end

    // One cycle: drive pending requests (garbage on idle ports), check grants and RAM mux.
    task automatic step();
        bit exp_i, exp_m;
        @(negedge clk);
        if_req_i    = if_p;
        if_addr_i   = if_p ? if_a : $urandom;
        mem_req_i   = mem_p;
        mem_addr_i  = mem_p ? mem_a : $urandom;
        mem_we_i    = mem_p ? mem_we : 4'($urandom);
        mem_wdata_i = mem_p ? mem_wd : $urandom;
        #1;
        // IF loses to MEM until it has been passed over LIMIT times in a row.
        exp_i = if_p && (!mem_p || if_wait == int'(LIMIT));
        exp_m = mem_p && !exp_i;
        chk("if_gnt", 32'(if_gnt_o), 32'(exp_i));
        chk("mem_gnt", 32'(mem_gnt_o), 32'(exp_m));
        chk("ram_en", 32'(ram_en_o), 32'(exp_i | exp_m));
        chk("ram_we", 32'(ram_we_o), exp_m ? 32'(mem_we) : 32'd0);
        chk("ram_addr", ram_addr_o, exp_m ? mem_a : (exp_i ? if_a : 32'd0));
        chk("ram_wdata", ram_wdata_o, exp_m ? mem_wd : 32'd0);
        got_if  = if_gnt_o;
        got_mem = mem_gnt_o;
        if (exp_i) begin
            if_q.push_back('{cyc: cyc + 1, data: ref_mem[if_a[7:2]], wr: 1'b0});
            if_p    = 1'b0;
            if_wait = 0;
        end else if (if_p) begin
            if_wait++;
        end
        if (exp_m) begin
            if (mem_we == 4'd0) begin
                mem_q.push_back('{cyc: cyc + 1, data: ref_mem[mem_a[7:2]], wr: 1'b0});
            end else begin
                ref_mem[mem_a[7:2]] = merge(ref_mem[mem_a[7:2]], mem_wd, mem_we);
                mem_q.push_back('{cyc: cyc + 1, data: 32'd0, wr: 1'b1});
            end
            mem_p = 1'b0;
        end
    endtask

    task automatic arm_if(input logic [31:0] a);
        if_p = 1'b1;
        if_a = a;
    endtask

    task automatic arm_mem(input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
        mem_p  = 1'b1;
        mem_we = we;
        mem_a  = a;
        mem_wd = wd;
    endtask

    function automatic logic [31:0] rand_addr();
        return {24'd0, 6'($urandom), 2'b00};
    endfunction

    task automatic conflict_run(output logic [9:0] seq);
        for (int i = 0; i < 10; i++) begin
            if (!if_p) arm_if(rand_addr());
            if (!mem_p) arm_mem(4'd0, rand_addr(), 32'd0);
            step();
            seq[i] = got_if;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (if_p || mem_p); i++) step();
        chk("drain bounded", 32'(if_p | mem_p), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [9:0] seq;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;

        // Reset with both requests asserted: everything must stay quiet.
        rstn_i      = 1'b0;
        if_req_i    = 1'b1;
        if_addr_i   = 32'h4;
        mem_req_i   = 1'b1;
        mem_we_i    = 4'hF;
        mem_addr_i  = 32'h8;
        mem_wdata_i = 32'h1234_5678;
        #7;
        chk("reset if_gnt", 32'(if_gnt_o), 32'd0);
        chk("reset mem_gnt", 32'(mem_gnt_o), 32'd0);
        chk("reset ram_en", 32'(ram_en_o), 32'd0);
        chk("reset ram_we", 32'(ram_we_o), 32'd0);
        chk("reset if_rvalid", 32'(if_rvalid_o), 32'd0);
        chk("reset mem_rvalid", 32'(mem_rvalid_o), 32'd0);
        @(negedge clk);
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
        @(negedge clk);
        rstn_i = 1'b1;
        step();

        // Fill RAM through the MEM port so reads never see undefined data.
        for (int i = 0; i < 64; i++) begin
            arm_mem(4'hF, 32'(i * 4), $urandom);
            step();
        end

        // IF-only stream.
        arm_mem(4'hF, 32'h0, 32'h11); step();
        arm_mem(4'hF, 32'h4, 32'h22); step();
        arm_mem(4'hF, 32'h8, 32'h33); step();
        for (int i = 0; i < 3; i++) begin
            arm_if(32'(i * 4));
            step();
        end
        step();

        // MEM full write, partial write, read back.
        arm_mem(4'hF, 32'h40, 32'hDEAD_BEEF); step();
        arm_mem(4'b0001, 32'h40, 32'h0000_00AA); step();
        arm_mem(4'h0, 32'h40, 32'h0); step();
        @(posedge clk);
        #2;
        chk("merged read", mem_rdata_o, 32'hDEAD_BEAA);
        step();

        // Continuous conflict.
        conflict_run(seq);
        chk("conflict grant seq", 32'(seq), 32'h210);
        drain();
        step();

        // Simultaneous first request.
        arm_if(32'h8);
        arm_mem(4'h0, 32'h10, 32'h0);
        step();
        chk("simul first mem", 32'(got_mem), 32'd1);
        step();
        chk("simul second if", 32'(got_if), 32'd1);

        // Idle.
        step();
        step();

        // Reset asserted in the cycle after an IF grant.
        arm_if(32'hC);
        step();
        @(negedge clk);
        if_req_i  = 1'b1;
        mem_req_i = 1'b1;
        mem_we_i  = 4'h0;
        #1;
        chk("pre-reset if_rvalid", 32'(if_rvalid_o), 32'd1);
        rstn_i = 1'b0;
        #1;
        chk("async if_rvalid", 32'(if_rvalid_o), 32'd0);
        chk("async ram_en", 32'(ram_en_o), 32'd0);
        chk("async if_gnt", 32'(if_gnt_o), 32'd0);
        chk("async mem_gnt", 32'(mem_gnt_o), 32'd0);
        if_p    = 1'b0;
        mem_p   = 1'b0;
        if_wait = 0;
        if_q.delete();
        mem_q.delete();
        @(posedge clk);
        #2;
        chk("in-reset if_rvalid", 32'(if_rvalid_o), 32'd0);
        chk("in-reset mem_rvalid", 32'(mem_rvalid_o), 32'd0);
        @(negedge clk);
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
        rstn_i    = 1'b1;
        for (int i = 0; i < 3; i++) step();
        conflict_run(seq);
        chk("post-reset grant seq", 32'(seq), 32'h210);
        drain();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if (!if_p && ($urandom_range(0, 2) == 0)) arm_if(rand_addr());
            if (!mem_p && ($urandom_range(0, 1) == 0)) begin
                if ($urandom_range(0, 1) == 0) arm_mem(4'h0, rand_addr(), 32'd0);
                else arm_mem(4'($urandom_range(1, 15)), rand_addr(), $urandom);
            end
            step();
        end
        drain();
        step();
        step();
        chk("scoreboard empty", 32'(if_q.size() + mem_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
